// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] OP_MAX = 4'b1000;

    logic [1:0]        state;
    logic              prio;       // requester that wins when both are valid
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              illegal_q;
    logic [1:0]        grant;
    logic              handshake;

    // Gated by rst_n so req_ready reads 0 during reset regardless of req_valid.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state == S_IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign handshake = |(grant & req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            op_q      <= 4'd0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        op_q  <= grant[1] ? req1_op : req0_op;
                        a_q   <= grant[1] ? req1_a  : req0_a;
                        b_q   <= grant[1] ? req1_b  : req0_b;
                        id_q  <= grant[1];
                        prio  <= ~grant[1];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q  <= alu_result;
                    zero_q    <= alu_zero;
                    illegal_q <= (op_q > OP_MAX);
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_ctrl    = op_q;
    assign rsp_valid   = (state == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = illegal_q;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed bench for alu_arbiter against a transaction model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal, busy;
    logic [31:0] rsp_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } rsp_t;
    rsp_t rsp_log[$];
    bit   grants[$];

    // Transaction-level model: one outstanding operation, last winner for tie-breaks.
    bit          m_pending;
    bit          m_last;
    int          m_hs;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    bit          m_id;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_rsp(input string tag, input int idx, input logic id, input logic [31:0] res,
                             input logic zero, input logic ill);
        check({tag, "_present"}, 32'(rsp_log.size() > idx), 32'd1);
        if (rsp_log.size() > idx) begin
            check({tag, "_id"},   32'(rsp_log[idx].id),   32'(id));
            check({tag, "_res"},  rsp_log[idx].res,       res);
            check({tag, "_zero"}, 32'(rsp_log[idx].zero), 32'(zero));
            check({tag, "_ill"},  32'(rsp_log[idx].ill),  32'(ill));
        end
    endtask

    task automatic check_grant(input string tag, input int idx, input bit exp);
        check({tag, "_present"}, 32'(grants.size() > idx), 32'd1);
        if (grants.size() > idx) check(tag, 32'(grants[idx]), 32'(exp));
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic do_cycle();
        logic [1:0]  exp_ready;
        bit          exp_rv;
        logic [31:0] exp_res;
        #1;
        if (!rst_n) begin
            check("rst_req_ready",   32'(req_ready),   32'd0);
            check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
            check("rst_busy",        32'(busy),        32'd0);
            check("rst_alu_a",       alu_a,            32'd0);
            check("rst_alu_b",       alu_b,            32'd0);
            check("rst_alu_ctrl",    32'(alu_ctrl),    32'd0);
            check("rst_rsp_id",      32'(rsp_id),      32'd0);
            check("rst_rsp_result",  rsp_result,       32'd0);
            check("rst_rsp_zero",    32'(rsp_zero),    32'd0);
            check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
            m_pending = 1'b0;
            m_last    = 1'b1;
        end else begin
            exp_ready = 2'b00;
            if (!m_pending) begin
                if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
                else                    exp_ready = req_valid;
            end
            exp_rv = m_pending && (cyc >= m_hs + 2);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("busy",      32'(busy),      32'(m_pending));
            if (m_pending) begin
                check("alu_ctrl", 32'(alu_ctrl), 32'(m_op));
                check("alu_a",    alu_a,         m_a);
                check("alu_b",    alu_b,         m_b);
            end
            if (exp_rv) begin
                exp_res = alu_f(m_op, m_a, m_b);
                check("rsp_id",      32'(rsp_id),      32'(m_id));
                check("rsp_result",  rsp_result,       exp_res);
                check("rsp_zero",    32'(rsp_zero),    32'(exp_res == 32'd0));
                check("rsp_illegal", 32'(rsp_illegal), 32'(m_op > 4'd8));
            end
            if ((req_ready & req_valid) != 2'b00) grants.push_back(req_ready[1]);
            if (rsp_valid && rsp_ready) rsp_log.push_back('{rsp_id, rsp_result, rsp_zero, rsp_illegal});
            if (exp_rv && rsp_ready) begin
                m_pending = 1'b0;
            end else if (exp_ready != 2'b00) begin
                m_id      = exp_ready[1];
                m_op      = m_id ? req1_op : req0_op;
                m_a       = m_id ? req1_a  : req0_a;
                m_b       = m_id ? req1_b  : req0_b;
                m_last    = m_id;
                m_hs      = cyc;
                m_pending = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        do_cycle();
        do_cycle();
        rst_n = 1'b1;
        rsp_log.delete();
        grants.delete();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        m_pending = 1'b0; m_last = 1'b1; m_hs = 0; m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_id = 1'b0;
        @(negedge clk);

        // Single requester add
        reset_dut();
        req_valid = 2'b01; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 1'b1;
        do_cycle();
        req_valid = 2'b00;
        repeat (3) do_cycle();
        check_rsp("d_add", 0, 1'b0, 32'd12, 1'b0, 1'b0);

        // Both valid: alternating grants
        reset_dut();
        req_valid = 2'b11; rsp_ready = 1'b1;
        req0_op = 4'd1; req0_a = 32'd9; req0_b = 32'd9;
        req1_op = 4'd2; req1_a = $urandom; req1_b = $urandom;
        repeat (9) do_cycle();
        req_valid = 2'b00;
        do_cycle();
        check_grant("d_rr0", 0, 1'b0);
        check_grant("d_rr1", 1, 1'b1);
        check_grant("d_rr2", 2, 1'b0);
        check_rsp("d_rr_first", 0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Back-pressure in RESP with both requesters waiting
        reset_dut();
        req_valid = 2'b10; req1_op = 4'd0; req1_a = 32'd3; req1_b = 32'd4; rsp_ready = 1'b0;
        do_cycle();
        req_valid = 2'b11;
        repeat (6) do_cycle();
        rsp_ready = 1'b1;
        do_cycle();
        do_cycle();
        req_valid = 2'b00;
        repeat (3) do_cycle();
        check_rsp("d_stall", 0, 1'b1, 32'd7, 1'b0, 1'b0);
        check_grant("d_stall_next", 1, 1'b0);

        // Illegal op
        reset_dut();
        req_valid = 2'b10; req1_op = 4'hF; req1_a = $urandom; req1_b = $urandom; rsp_ready = 1'b1;
        do_cycle();
        req_valid = 2'b00;
        do_cycle();
        check("d_ill_ctrl", 32'(alu_ctrl), 32'hF);
        repeat (2) do_cycle();
        check_rsp("d_ill", 0, 1'b1, 32'd0, 1'b1, 1'b1);

        // Reset pulse during EXEC
        reset_dut();
        req_valid = 2'b10; req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd2;
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2; rsp_ready = 1'b1;
        do_cycle();
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        req_valid = 2'b11;
        do_cycle();
        req_valid = 2'b00;
        repeat (3) do_cycle();
        check_grant("d_abort_grant", 1, 1'b0);
        check_rsp("d_abort", 0, 1'b0, 32'd3, 1'b0, 1'b0);
        check("d_abort_count", 32'(rsp_log.size()), 32'd1);

        // Op 1000 boundary and operand change during EXEC
        reset_dut();
        req_valid = 2'b01; req0_op = 4'b1000; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; rsp_ready = 1'b1;
        do_cycle();
        req_valid = 2'b00; req0_a = 32'h1234_5678;
        do_cycle();
        check("d_slt_alu_a", alu_a, 32'hFFFF_FFFF);
        repeat (2) do_cycle();
        check_rsp("d_slt", 0, 1'b0, 32'd1, 1'b0, 1'b0);

        // Randomized traffic with occasional resets
        reset_dut();
        repeat (3000) begin
            rst_n     = ($urandom % 256) != 0;
            req_valid = 2'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            req0_op   = 4'($urandom);
            req1_op   = 4'($urandom);
            req0_a    = $urandom;
            req1_a    = $urandom;
            req0_b    = (($urandom % 4) == 0) ? req0_a : $urandom;
            req1_b    = (($urandom % 4) == 0) ? req1_a : $urandom;
            do_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
